// File: rtl/stream_fifo_buf.sv
// stream_fifo_buf: parametrised single-clock stream buffer with first-word
// fall-through output, occupancy level, almost-full flag and synchronous flush.
//
// Handshake: a word moves on a port only on a rising edge where valid and
// ready are both high. in_ready depends only on the registered level (never
// on out_ready), so a full buffer refuses input even while it is being
// drained. out_valid/out_data likewise depend only on registered state, so
// there is no combinational path from any input to any output.
module stream_fifo_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AF_THR = 3,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Status flags come from the registered level only.
    assign full        = (level_q == LVL_W'(DEPTH));
    assign empty       = (level_q == '0);
    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign almost_full = (level_q >= LVL_W'(AF_THR));
    assign level       = level_q;

    // Empty buffer presents zero rather than stale storage contents.
    assign out_data = empty ? '0 : mem_q[rd_ptr_q];

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    // Next-state pointers and level; flush overrides any same-cycle transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; the array is deliberately not reset, level guards reads.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Occupancy can never exceed the storage size.
    level_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        level_q <= LVL_W'(DEPTH));

endmodule

// File: tb/tb_stream_fifo_buf.sv
// tb_stream_fifo_buf: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the buffer.
module tb_stream_fifo_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AF_THR = 3;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              almost_full;

  int total;
  int bad;

  // expected stored words, oldest first
  logic [DATA_W-1:0] exp_q[$];

  stream_fifo_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AF_THR(AF_THR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .almost_full(almost_full)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // compare every output against the model state
  task automatic check_outputs(input string tag);
    int n;
    logic [DATA_W-1:0] head;
    n    = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    check_eq({tag, ".level"},       32'(level),       32'(n));
    check_eq({tag, ".in_ready"},    32'(in_ready),    32'(n < DEPTH));
    check_eq({tag, ".out_valid"},   32'(out_valid),   32'(n > 0));
    check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF_THR));
    check_eq({tag, ".out_data"},    32'(out_data),    32'(head));
  endtask

  // one clock: check outputs, advance the model by the buffer's rules
  task automatic cycle(input string tag);
    bit do_push;
    bit do_pop;
    logic [DATA_W-1:0] wd;
    check_outputs(tag);
    do_push = in_valid && (exp_q.size() < DEPTH);
    do_pop  = out_ready && (exp_q.size() > 0);
    wd      = in_data;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(wd);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    logic [DATA_W-1:0] seq3 [3];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // 1 reset
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // 2 push three with back-pressure, then drain
    seq3[0] = 8'h10; seq3[1] = 8'h20; seq3[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seq3[i], 1'b0, 1'b0);
      cycle("bp_push");
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle("bp_hold");
    cycle("bp_hold2");
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) cycle("bp_drain");

    // 3 fill, overfill attempt, one pop, late accept
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
      cycle("fill");
    end
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    cycle("full_refuse");
    cycle("full_refuse2");
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    cycle("full_pop");
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    cycle("late_accept");
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (6) cycle("fill_drain");

    // 4 pointer wrap with streaming push+pop
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
      cycle("wrap");
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) cycle("wrap_drain");

    // 5 flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DATA_W'(8'h30 + i), 1'b0, 1'b0);
      cycle("pre_flush");
    end
    drive(1'b1, 8'hAA, 1'b1, 1'b1);
    cycle("flush");
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle("post_flush");

    // 6 async reset between edges
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    cycle("pre_rst");
    drive(1'b1, 8'h42, 1'b0, 1'b0);
    cycle("pre_rst2");
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_outputs("async_rst");
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle("post_rst_push");
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) cycle("post_rst_pop");

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 99) < 60),
            DATA_W'($urandom),
            1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 49) == 0));
      cycle("rand");
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (DEPTH + 1) cycle("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
